// File: rtl/gpio_ctrl_pkg.sv
// Shared types for the GPIO event controller.
// Only width-independent definitions live here.
package gpio_ctrl_pkg;

  typedef enum logic [1:0] {
    GPIO_WR_LOAD   = 2'd0,
    GPIO_WR_SET    = 2'd1,
    GPIO_WR_CLEAR  = 2'd2,
    GPIO_WR_TOGGLE = 2'd3
  } gpio_wr_op_e;

endpackage

// File: rtl/gpio_evt_fifo.sv
// Synchronous event FIFO, one push and one pop per cycle.
// Pointers carry an extra wrap bit to tell full from empty.
module gpio_evt_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  output logic          full_o,
  output logic          empty_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [DW-1:0] data_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic          pop;
  logic          push_ok;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign valid_o = ~empty_o;
  assign pop     = valid_o & ready_i;
  // A pop frees the slot in the same edge, so full can still accept.
  assign push_ok = push_i & (~full_o | pop);
  assign data_o  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop)     rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/gpio_event_ctrl.sv
// GPIO controller: synchronised, debounced, time-stamped read events
// plus a masked load/set/clear/toggle write port.
module gpio_event_ctrl
  import gpio_ctrl_pkg::*;
#(
  parameter int unsigned READ_PORT_WIDTH  = 4,
  parameter int unsigned WRITE_PORT_WIDTH = 4,
  parameter int unsigned DEBOUNCE_CYCLES  = 4,
  parameter int unsigned FIFO_DEPTH       = 8,
  parameter int unsigned TS_WIDTH         = 16,
  parameter logic [WRITE_PORT_WIDTH-1:0] WRITE_RESET_VAL = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [READ_PORT_WIDTH-1:0]  read_port,
  output logic [WRITE_PORT_WIDTH-1:0] write_port,
  input  logic                        wr_en,
  input  logic [1:0]                  wr_op,
  input  logic [WRITE_PORT_WIDTH-1:0] wr_data,
  input  logic [WRITE_PORT_WIDTH-1:0] wr_mask,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [READ_PORT_WIDTH-1:0]  evt_value,
  output logic [READ_PORT_WIDTH-1:0]  evt_rise,
  output logic [READ_PORT_WIDTH-1:0]  evt_fall,
  output logic [TS_WIDTH-1:0]         evt_ts,
  output logic                        evt_overflow,
  input  logic                        ovf_clr,
  output logic                        irq
);

  localparam int unsigned RW = READ_PORT_WIDTH;
  localparam int unsigned WW = WRITE_PORT_WIDTH;
  localparam int unsigned CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned EW = TS_WIDTH + 3 * RW;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [RW-1:0]       sync1_q;
  logic [RW-1:0]       sync2_q;
  logic [RW-1:0]       stable_q, stable_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [TS_WIDTH-1:0] ts_q;
  logic                ovf_q, ovf_d;
  logic [WW-1:0]       wp_q, wp_d;
  logic [WW-1:0]       wm;
  logic                push;
  logic                drop;
  logic [EW-1:0]       push_data;
  logic [EW-1:0]       head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_valid;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      push     = 1'b1;
      cnt_d    = '0;
    end else if (sync1_q != sync2_q) begin
      // sync2 is about to change, so its run restarts
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign push_data = {ts_q,
                      ~sync2_q & stable_q,
                      sync2_q & ~stable_q,
                      sync2_q};

  assign drop = push & fifo_full & ~(evt_ready & ~fifo_empty);

  always_comb begin
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  assign wm = wr_data & wr_mask;

  always_comb begin
    wp_d = wp_q;
    if (wr_en) begin
      unique case (gpio_wr_op_e'(wr_op))
        GPIO_WR_LOAD:   wp_d = (wp_q & ~wr_mask) | wm;
        GPIO_WR_SET:    wp_d = wp_q | wm;
        GPIO_WR_CLEAR:  wp_d = wp_q & ~wm;
        GPIO_WR_TOGGLE: wp_d = wp_q ^ wm;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      ts_q     <= '0;
      ovf_q    <= 1'b0;
      wp_q     <= WRITE_RESET_VAL;
    end else begin
      sync1_q  <= read_port;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      ts_q     <= ts_q + 1'b1;
      ovf_q    <= ovf_d;
      wp_q     <= wp_d;
    end
  end

  gpio_evt_fifo #(
    .DW    (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .valid_o (fifo_valid),
    .ready_i (evt_ready),
    .data_o  (head)
  );

  assign evt_valid    = fifo_valid;
  assign {evt_ts, evt_fall, evt_rise, evt_value} =
    fifo_valid ? head : '0;
  assign evt_overflow = ovf_q;
  assign irq          = fifo_valid | ovf_q;
  assign write_port   = wp_q;

endmodule

// File: tb/tb_gpio_event_ctrl.sv
// Bench for gpio_event_ctrl: directed steps plus random traffic
// compared every cycle against a window-based event model.
module tb_gpio_event_ctrl;
  import gpio_ctrl_pkg::*;

  localparam int RW  = 4;
  localparam int WW  = 4;
  localparam int D   = 4;
  localparam int DEP = 8;
  localparam int TSW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] read_port;
  logic [WW-1:0] write_port;
  logic          wr_en;
  logic [1:0]    wr_op;
  logic [WW-1:0] wr_data;
  logic [WW-1:0] wr_mask;
  logic          evt_valid;
  logic          evt_ready;
  logic [RW-1:0] evt_value;
  logic [RW-1:0] evt_rise;
  logic [RW-1:0] evt_fall;
  logic [TSW-1:0] evt_ts;
  logic          evt_overflow;
  logic          ovf_clr;
  logic          irq;

  always #5 clk = ~clk;

  gpio_event_ctrl #(
    .READ_PORT_WIDTH  (RW),
    .WRITE_PORT_WIDTH (WW),
    .DEBOUNCE_CYCLES  (D),
    .FIFO_DEPTH       (DEP),
    .TS_WIDTH         (TSW),
    .WRITE_RESET_VAL  (4'b0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .read_port    (read_port),
    .write_port   (write_port),
    .wr_en        (wr_en),
    .wr_op        (wr_op),
    .wr_data      (wr_data),
    .wr_mask      (wr_mask),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_value    (evt_value),
    .evt_rise     (evt_rise),
    .evt_fall     (evt_fall),
    .evt_ts       (evt_ts),
    .evt_overflow (evt_overflow),
    .ovf_clr      (ovf_clr),
    .irq          (irq)
  );

  typedef struct {
    logic [RW-1:0]  v;
    logic [RW-1:0]  r;
    logic [RW-1:0]  f;
    logic [TSW-1:0] ts;
  } ev_t;

  logic [RW-1:0] samp[$];
  logic [RW-1:0] vh[$];
  logic [RW-1:0] st_m;
  int            ts_m;
  ev_t           mq[$];
  bit            ovf_m;
  logic [WW-1:0] wp_m;
  int            npass = 0;
  int            ntot = 0;
  string         cur_tag = "init";

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: an input value is accepted once the synchronised sample
  // has held the same non-stable value for D consecutive edges.
  task automatic model_edge();
    logic [RW-1:0] v;
    logic [WW-1:0] m;
    bit acc;
    bit dropped;
    ev_t e;
    if (rst) begin
      samp = '{4'h0, 4'h0};
      vh.delete();
      st_m = '0;
      ts_m = 0;
      mq.delete();
      ovf_m = 1'b0;
      wp_m = 4'b0000;
      return;
    end
    v = samp[samp.size() - 2];
    vh.push_back(v);
    if (vh.size() > D) void'(vh.pop_front());
    acc = (v != st_m) && (vh.size() == D);
    foreach (vh[i]) if (vh[i] != v) acc = 1'b0;
    if (evt_ready && mq.size() > 0) void'(mq.pop_front());
    dropped = 1'b0;
    if (acc) begin
      e.v = v;
      e.r = v & ~st_m;
      e.f = ~v & st_m;
      e.ts = ts_m[TSW-1:0];
      st_m = v;
      if (mq.size() < DEP) mq.push_back(e);
      else dropped = 1'b1;
    end
    if (dropped) ovf_m = 1'b1;
    else if (ovf_clr) ovf_m = 1'b0;
    ts_m = (ts_m + 1) % (1 << TSW);
    if (wr_en) begin
      m = wr_data & wr_mask;
      case (wr_op)
        2'd0: wp_m = (wp_m & ~wr_mask) | m;
        2'd1: wp_m = wp_m | m;
        2'd2: wp_m = wp_m & ~m;
        default: wp_m = wp_m ^ m;
      endcase
    end
    samp.push_back(read_port);
    if (samp.size() > 2) void'(samp.pop_front());
  endtask

  task automatic check_out(string tag);
    ev_t h;
    bit hv;
    hv = mq.size() > 0;
    if (hv) h = mq[0];
    else h = '{default: '0};
    chk({tag, ".valid"}, evt_valid, hv);
    chk({tag, ".value"}, evt_value, h.v);
    chk({tag, ".rise"}, evt_rise, h.r);
    chk({tag, ".fall"}, evt_fall, h.f);
    chk({tag, ".ts"}, evt_ts, h.ts);
    chk({tag, ".ovf"}, evt_overflow, ovf_m);
    chk({tag, ".irq"}, irq, hv | ovf_m);
    chk({tag, ".wp"}, write_port, wp_m);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_out(cur_tag);
  endtask

  task automatic pop1();
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
  endtask

  initial begin
    logic [TSW-1:0] t1;
    logic [TSW-1:0] t2;
    logic [TSW-1:0] td;
    int n;
    int hold;

    rst = 1'b1;
    read_port = 4'b1001;
    wr_en = 1'b0;
    wr_op = 2'd0;
    wr_data = '0;
    wr_mask = '0;
    evt_ready = 1'b0;
    ovf_clr = 1'b0;

    cur_tag = "reset";
    repeat (3) step();
    chk("reset.wp_const", write_port, 4'b0000);
    chk("reset.valid_const", evt_valid, 0);

    rst = 1'b0;
    cur_tag = "snap";
    repeat (5) step();
    chk("snap.early", evt_valid, 0);
    step();
    chk("snap.value_const", evt_value, 4'b1001);
    chk("snap.rise_const", evt_rise, 4'b1001);
    chk("snap.ts_const", evt_ts, 5);
    pop1();

    cur_tag = "deb";
    read_port = 4'b0000;
    repeat (8) step();
    pop1();
    read_port = 4'b0101;
    repeat (5) step();
    chk("deb.early", evt_valid, 0);
    step();
    chk("deb.value_const", evt_value, 4'b0101);
    chk("deb.rise_const", evt_rise, 4'b0101);
    chk("deb.fall_const", evt_fall, 4'b0000);
    pop1();

    cur_tag = "glitch";
    read_port = 4'b0000;
    repeat (8) step();
    pop1();
    read_port = 4'b1000;
    repeat (3) step();
    read_port = 4'b0000;
    repeat (10) step();
    chk("glitch.none", evt_valid, 0);

    cur_tag = "wr";
    wr_en = 1'b1;
    wr_op = GPIO_WR_LOAD; wr_data = 4'b1111; wr_mask = 4'b0011;
    step();
    chk("wr.load", write_port, 4'b0011);
    wr_op = GPIO_WR_SET; wr_data = 4'b0100; wr_mask = 4'b1111;
    step();
    chk("wr.set", write_port, 4'b0111);
    wr_op = GPIO_WR_CLEAR; wr_data = 4'b0001; wr_mask = 4'b1111;
    step();
    chk("wr.clear", write_port, 4'b0110);
    wr_op = GPIO_WR_TOGGLE; wr_data = 4'b1111; wr_mask = 4'b1001;
    step();
    chk("wr.toggle", write_port, 4'b1111);
    wr_en = 1'b0;
    step();
    chk("wr.hold", write_port, 4'b1111);

    cur_tag = "ovf";
    for (int i = 0; i < 9; i++) begin
      read_port = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      repeat (6) step();
    end
    chk("ovf.flag", evt_overflow, 1);
    chk("ovf.irq", irq, 1);
    read_port = 4'b0000;
    repeat (5) step();
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf.set_wins", evt_overflow, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf.cleared", evt_overflow, 0);

    cur_tag = "fullpp";
    read_port = 4'b0001;
    repeat (5) step();
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    chk("fullpp.no_drop", evt_overflow, 0);
    evt_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 20 && evt_valid; k++) begin
      step();
      n++;
    end
    evt_ready = 1'b0;
    chk("fullpp.count", n, 8);

    cur_tag = "drain";
    read_port = 4'b0000;
    repeat (6) step();
    chk("drain.fall_const", evt_fall, 4'b0001);
    chk("drain.rise_const", evt_rise, 4'b0000);
    pop1();

    cur_tag = "tswrap";
    read_port = 4'b0010;
    repeat (20) step();
    read_port = 4'b0000;
    repeat (20) step();
    t1 = evt_ts;
    pop1();
    t2 = evt_ts;
    td = t2 - t1;
    chk("tswrap.diff", td, 4);
    pop1();

    cur_tag = "flush";
    read_port = 4'b0110;
    repeat (8) step();
    chk("flush.pre", evt_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("flush.post", evt_valid, 0);

    cur_tag = "rand";
    hold = 0;
    for (int it = 0; it < 3000; it++) begin
      if (hold == 0) begin
        read_port = 4'($urandom());
        hold = $urandom_range(1, 8);
      end
      hold--;
      evt_ready = ($urandom_range(0, 3) == 0);
      ovf_clr = ($urandom_range(0, 15) == 0);
      wr_en = 1'($urandom());
      wr_op = 2'($urandom());
      wr_data = 4'($urandom());
      wr_mask = 4'($urandom());
      rst = (it == 1500);
      step();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
